// File: rtl/nios2_cpu_debug_ocimem_pkg.sv
// Shared types and jdo field layout for the OCI debug-memory block.
// The jdo word carries the address, read-arm flag and write data of JTAG transactions.
package nios2_cpu_debug_ocimem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_JRD,
        ST_JCAP,
        ST_JWR,
        ST_CRD
    } ocimem_state_e;

    localparam int unsigned JDO_W           = 38;
    localparam int unsigned JDO_RD_FLAG_BIT = 35;
    localparam int unsigned JDO_ADDR_LSB    = 17;
    localparam int unsigned JDO_DATA_LSB    = 3;
    localparam int unsigned JDO_DATA_W      = 32;

endpackage

// File: rtl/nios2_cpu_debug_ocimem_ram.sv
// Single-port synchronous debug RAM, 32-bit words with byte enables.
// Read data is registered, so q_o reflects the address presented on the previous cycle.
module nios2_cpu_debug_ocimem_ram #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              we_i,
    input  logic [3:0]        be_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       q_o
);

    logic [31:0] mem_q [2**ADDR_W];
    logic [31:0] q_q;

    // Read-before-write: a same-cycle write returns the old word on q_o.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
        q_q <= mem_q[addr_i];
    end

    assign q_o = q_q;

endmodule

// File: rtl/nios2_cpu_debug_ocimem.sv
// OCI debug memory: JTAG-driven monitor reads/writes plus a CPU Avalon-MM slave
// sharing one single-port RAM, with JTAG given priority over the CPU.
module nios2_cpu_debug_ocimem
    import nios2_cpu_debug_ocimem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned RD_FLAG_BIT = JDO_RD_FLAG_BIT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic [3:0]        byteenable,
    input  logic              debugaccess,
    output logic [31:0]       readdata,
    output logic              waitrequest,
    output logic [31:0]       MonDReg,
    output logic [ADDR_W+1:0] MonAReg,
    output logic              jtag_overrun
);

    localparam logic [ADDR_W+1:0] MON_A_STEP = (ADDR_W+2)'(4);

    ocimem_state_e     state_q;
    logic [31:0]       mon_d_q;
    logic [ADDR_W+1:0] mon_a_q;
    logic              rd_flag_q;
    logic              overrun_q;
    logic [31:0]       readdata_q;

    logic              jtag_any;
    logic              cpu_wr_ok;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [3:0]        ram_be;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_q;
    logic              unused_jdo;

    assign jtag_any  = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    assign cpu_wr_ok = reset_n && (state_q == ST_IDLE) && !jtag_any && write;

    always_comb begin
        ram_addr  = address;
        ram_we    = 1'b0;
        ram_be    = byteenable;
        ram_wdata = writedata;
        case (state_q)
            ST_JRD: begin
                ram_addr = mon_a_q[ADDR_W+1:2];
            end
            ST_JWR: begin
                ram_addr  = mon_a_q[ADDR_W+1:2];
                ram_we    = 1'b1;
                ram_be    = '1;
                ram_wdata = mon_d_q;
            end
            ST_IDLE: begin
                ram_we = cpu_wr_ok & debugaccess;
            end
            default: begin
            end
        endcase
    end

    nios2_cpu_debug_ocimem_ram #(
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk_i  (clk),
        .addr_i (ram_addr),
        .we_i   (ram_we),
        .be_i   (ram_be),
        .wdata_i(ram_wdata),
        .q_o    (ram_q)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            mon_d_q    <= '0;
            mon_a_q    <= '0;
            rd_flag_q  <= 1'b0;
            overrun_q  <= 1'b0;
            readdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (take_action_ocimem_a) begin
                        mon_a_q   <= {jdo[JDO_ADDR_LSB +: ADDR_W], 2'b00};
                        rd_flag_q <= jdo[RD_FLAG_BIT];
                        overrun_q <= 1'b0;
                        if (jdo[RD_FLAG_BIT]) begin
                            state_q <= ST_JRD;
                        end
                    end else if (take_action_ocimem_b) begin
                        mon_d_q <= jdo[JDO_DATA_LSB +: JDO_DATA_W];
                        state_q <= ST_JWR;
                    end else if (take_no_action_ocimem_a) begin
                        if (rd_flag_q) begin
                            state_q <= ST_JRD;
                        end
                    end else if (read && !write) begin
                        state_q <= ST_CRD;
                    end
                end
                ST_JRD: begin
                    state_q <= ST_JCAP;
                end
                ST_JCAP: begin
                    mon_d_q <= ram_q;
                    mon_a_q <= mon_a_q + MON_A_STEP;
                    state_q <= ST_IDLE;
                end
                ST_JWR: begin
                    mon_a_q <= mon_a_q + MON_A_STEP;
                    state_q <= ST_IDLE;
                end
                ST_CRD: begin
                    readdata_q <= ram_q;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
            // Pulses only land in IDLE; anything arriving mid-transaction is lost.
            if ((state_q != ST_IDLE) && jtag_any) begin
                overrun_q <= 1'b1;
            end
        end
    end

    // readdata is live from the RAM in CRD so data is valid alongside waitrequest=0.
    assign readdata     = (state_q == ST_CRD) ? ram_q : readdata_q;
    assign waitrequest  = ~(cpu_wr_ok | (state_q == ST_CRD));
    assign MonDReg      = mon_d_q;
    assign MonAReg      = mon_a_q;
    assign jtag_overrun = overrun_q;
    assign unused_jdo   = ^jdo;

endmodule
